// File: rtl/stream_demux.sv
// Registered 1-to-2 valid/ready stream demultiplexer.
// Each output has its own circular-buffer FIFO and a wrapping pop counter.
module stream_demux #(
  parameter int DW    = 31,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic          aclk,
  input  logic          arst,
  input  logic [DW-1:0] din,
  input  logic          din_sel,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [DW-1:0] res0,
  output logic          res0_valid,
  input  logic          res0_ready,
  output logic [DW-1:0] res1,
  output logic          res1_valid,
  input  logic          res1_ready,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  logic [1:0]    full;
  logic [1:0]    empty;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    rdy;
  logic [DW-1:0] head [2];
  logic [CW-1:0] cnt  [2];

  // A full target FIFO refuses the beat even if it pops this cycle.
  assign din_ready = ~full[din_sel];
  assign push      = {din_valid & din_ready & din_sel, din_valid & din_ready & ~din_sel};
  assign rdy       = {res1_ready, res0_ready};
  assign pop       = rdy & ~empty;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [OW-1:0] occ;
    logic [CW-1:0] pops;

    always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
        mem  <= '{default: '0};
        wptr <= '0;
        rptr <= '0;
        occ  <= '0;
        pops <= '0;
      end else begin
        if (push[g]) begin
          mem[wptr] <= din;
          wptr      <= wptr + PW'(1);
        end
        if (pop[g]) begin
          rptr <= rptr + PW'(1);
          pops <= pops + CW'(1);
        end
        if (push[g] && !pop[g]) begin
          occ <= occ + OW'(1);
        end else if (!push[g] && pop[g]) begin
          occ <= occ - OW'(1);
        end
      end
    end

    assign full[g]  = (occ == OW'(DEPTH));
    assign empty[g] = (occ == '0);
    assign head[g]  = mem[rptr];
    assign cnt[g]   = pops;
  end

  assign res0       = head[0];
  assign res1       = head[1];
  assign res0_valid = ~empty[0];
  assign res1_valid = ~empty[1];
  assign cnt0       = cnt[0];
  assign cnt1       = cnt[1];

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: per-output expected queues, checked by a
// negedge monitor against a queue-based reference model.
module tb_stream_demux;

  localparam int DW    = 31;
  localparam int DEPTH = 2;
  localparam int CW    = 8;

  logic          aclk = 1'b0;
  logic          arst = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_sel = 1'b0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [DW-1:0] res0;
  logic          res0_valid;
  logic          res0_ready = 1'b0;
  logic [DW-1:0] res1;
  logic          res1_valid;
  logic          res1_ready = 1'b0;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int unsigned   ecnt0 = 0;
  int unsigned   ecnt1 = 0;
  logic          er;
  logic          rdone = 1'b0;

  stream_demux #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .aclk(aclk), .arst(arst),
    .din(din), .din_sel(din_sel), .din_valid(din_valid), .din_ready(din_ready),
    .res0(res0), .res0_valid(res0_valid), .res0_ready(res0_ready),
    .res1(res1), .res1_valid(res1_valid), .res1_ready(res1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs only change just after rising edges, so values seen here
  // are exactly what the next rising edge will act on.
  always @(negedge aclk) begin
    if (arst) begin
      q0.delete();
      q1.delete();
      ecnt0 = 0;
      ecnt1 = 0;
      chk("rst_valid0", res0_valid, 0);
      chk("rst_valid1", res1_valid, 0);
      chk("rst_cnt0", cnt0, 0);
      chk("rst_cnt1", cnt1, 0);
    end else begin
      er = din_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
      chk("din_ready", din_ready, er);
      chk("res0_valid", res0_valid, q0.size() != 0);
      chk("res1_valid", res1_valid, q1.size() != 0);
      chk("cnt0", cnt0, ecnt0 % (1 << CW));
      chk("cnt1", cnt1, ecnt1 % (1 << CW));
      if (q0.size() != 0) begin
        chk("res0_data", res0, q0[0]);
        if (res0_ready) begin
          void'(q0.pop_front());
          ecnt0++;
        end
      end
      if (q1.size() != 0) begin
        chk("res1_data", res1, q1[0]);
        if (res1_ready) begin
          void'(q1.pop_front());
          ecnt1++;
        end
      end
      if (din_valid && er) begin
        if (din_sel) q1.push_back(din);
        else         q0.push_back(din);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Offer one beat and hold it until accepted (bounded); returns 1 ns after the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic s);
    int unsigned n = 0;
    din = d;
    din_sel = s;
    din_valid = 1'b1;
    forever begin
      @(negedge aclk);
      if (din_ready) break;
      n++;
      if (n > 400) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got din_ready=0 expected accept within 400 cycles");
        break;
      end
    end
    @(posedge aclk);
    #1;
    din_valid = 1'b0;
  endtask

  initial begin
    #1 arst = 1'b1;
    cyc(3);
    arst = 1'b0;
    cyc(1);

    // Routing and one-cycle latency
    res0_ready = 1'b1;
    res1_ready = 1'b1;
    send(31'h0000001, 1'b0);
    chk("route_v0", res0_valid, 1);
    chk("route_d0", res0, 31'h0000001);
    send(31'h7FFFFFF, 1'b1);
    chk("route_v1", res1_valid, 1);
    chk("route_d1", res1, 31'h7FFFFFF);
    cyc(3);
    chk("route_cnt0", cnt0, 1);
    chk("route_cnt1", cnt1, 1);

    // Backpressure on output 0; held beat retargeted to output 1
    res0_ready = 1'b0;
    res1_ready = 1'b0;
    send(31'h0A0A0A0, 1'b0);
    send(31'h0A1A1A1, 1'b0);
    din = 31'h00BBBBB;
    din_sel = 1'b0;
    din_valid = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      chk("bp_ready", din_ready, 0);
    end
    @(posedge aclk);
    #1;
    send(31'h00BBBBB, 1'b1);
    chk("bp_other_v1", res1_valid, 1);
    chk("bp_other_d1", res1, 31'h00BBBBB);

    // Stall stability then in-order drain
    send(31'h00CCCCC, 1'b1);
    repeat (5) begin
      @(negedge aclk);
      chk("stall_v1", res1_valid, 1);
      chk("stall_d1", res1, 31'h00BBBBB);
    end
    @(posedge aclk);
    #1;
    res0_ready = 1'b1;
    res1_ready = 1'b1;
    cyc(6);
    chk("drain_cnt0", cnt0, 3);
    chk("drain_cnt1", cnt1, 3);

    // Full FIFO popping: no pass-through on the same cycle
    res0_ready = 1'b0;
    send(31'h0D00000, 1'b0);
    send(31'h0D11111, 1'b0);
    res0_ready = 1'b1;
    din = 31'h0D22222;
    din_sel = 1'b0;
    din_valid = 1'b1;
    @(negedge aclk);
    chk("fullpop_ready0", din_ready, 0);
    @(posedge aclk);
    #1;
    @(negedge aclk);
    chk("fullpop_ready1", din_ready, 1);
    @(posedge aclk);
    #1;
    din_valid = 1'b0;
    cyc(5);
    chk("fullpop_cnt0", cnt0, 6);

    // Reset mid-stream with both FIFOs full
    res0_ready = 1'b0;
    res1_ready = 1'b0;
    send(31'h0E00000, 1'b0);
    send(31'h0E11111, 1'b0);
    send(31'h0F00000, 1'b1);
    send(31'h0F11111, 1'b1);
    arst = 1'b1;
    #1;
    chk("arst_v0", res0_valid, 0);
    chk("arst_v1", res1_valid, 0);
    chk("arst_cnt0", cnt0, 0);
    chk("arst_cnt1", cnt1, 0);
    chk("arst_d0", res0, 0);
    chk("arst_d1", res1, 0);
    cyc(2);
    arst = 1'b0;
    cyc(1);

    // Counter wrap on output 1
    res0_ready = 1'b1;
    res1_ready = 1'b1;
    for (int i = 0; i < 256; i++) send(DW'(i + 32'h100), 1'b1);
    cyc(4);
    chk("wrap_cnt1", cnt1, 0);
    chk("wrap_cnt0", cnt0, 0);

    // Randomized traffic with random consumer stalls
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) cyc(1);
          send(DW'($urandom()), 1'($urandom_range(1)));
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge aclk);
          #1;
          res0_ready = 1'($urandom_range(1));
          res1_ready = 1'($urandom_range(1));
        end
      end
    join
    res0_ready = 1'b1;
    res1_ready = 1'b1;
    cyc(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
